// File: rtl/axis_fifo_if.sv
// AXI-Stream bundle carrying tdata/tkeep/tlast/tuser/tid/tdest with valid/ready.
// The producer side uses the master modport; the consumer side uses the slave modport.
interface axis_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tid, tdest, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tid, tdest, tvalid, output tready);
endinterface

// File: rtl/axis_fifo.sv
// AXIS FIFO with output register, optional store-and-forward and oversize-frame drop.
// First beat visible two edges after its write (or its frame's tlast); tready = !full, forced high while sinking a dropped frame.
module axis_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 1,
    parameter int ID_WIDTH      = 1,
    parameter int DEST_WIDTH    = 1,
    parameter int DEPTH         = 16,
    parameter int FRAME_FIFO    = 0,
    parameter int DROP_OVERSIZE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_fifo_if.slave             s_axis,
    axis_fifo_if.master            m_axis,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   overflow,
    output logic                   frame_dropped
);
    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam bit FRAME_EN = (FRAME_FIFO != 0);
    localparam bit DROP_EN  = (FRAME_FIFO != 0) && (DROP_OVERSIZE != 0);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
    } beat_t;

    typedef enum logic {ST_IDLE, ST_DROP} wr_state_e;

    beat_t     mem_q [DEPTH];
    beat_t     in_beat;
    beat_t     out_q, out_d;
    wr_state_e state_q, state_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, cm_q, cm_d;
    logic [AW:0] occ, unc;
    logic      out_vld_q, out_vld_d;
    logic      ovf_q, ovf_d, fdrop_q, fdrop_d;
    logic      full, oversize, s_rdy, s_acc, mem_we, readable, ld;

    always_comb begin
        in_beat = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast,
                    user: s_axis.tuser, id: s_axis.tid, dest: s_axis.tdest};
    end

    // Write side: the occupancy seen by the producer includes the output register.
    always_comb begin
        occ      = (wr_q - rd_q) + PW'(out_vld_q);
        unc      = wr_q - cm_q;
        full     = (occ == PW'(DEPTH));
        oversize = DROP_EN && (state_q == ST_IDLE) && full && (unc == PW'(DEPTH));
        s_rdy    = rst && ((state_q == ST_DROP) || oversize || !full);
        s_acc    = s_axis.tvalid && s_rdy;

        wr_d     = wr_q;
        cm_d     = cm_q;
        state_d  = state_q;
        ovf_d    = 1'b0;
        fdrop_d  = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_acc) begin
                    if (oversize) begin
                        // Frame can never fit: rewind to the last committed frame and sink the rest.
                        wr_d  = cm_q;
                        ovf_d = 1'b1;
                        if (s_axis.tlast) begin
                            fdrop_d = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        mem_we = 1'b1;
                        wr_d   = wr_q + PW'(1);
                        if (s_axis.tlast) begin
                            cm_d = wr_q + PW'(1);
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_acc) begin
                    ovf_d = 1'b1;
                    if (s_axis.tlast) begin
                        fdrop_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!FRAME_EN) begin
            cm_d = wr_d;
        end
    end

    // Read side: the output register refills whenever it is empty or being drained.
    always_comb begin
        readable  = (cm_q != rd_q);
        ld        = readable && (!out_vld_q || m_axis.tready);
        rd_d      = rd_q + PW'(ld);
        out_vld_d = ld || (out_vld_q && !m_axis.tready);
        out_d     = ld ? mem_q[rd_q[AW-1:0]] : out_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_q[AW-1:0]] <= in_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            cm_q      <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            fdrop_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cm_q      <= cm_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            fdrop_q   <= fdrop_d;
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = out_vld_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tkeep  = out_q.keep;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tid    = out_q.id;
    assign m_axis.tdest  = out_q.dest;
    assign occupancy     = occ;
    assign overflow      = ovf_q;
    assign frame_dropped = fdrop_q;
endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: dut0 is a plain FIFO, dut1 is store-and-forward with oversize drop.
// Expected beats are queued when written and compared in order when the DUT presents them.
module tb_axis_fifo;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [1:0]  u;
        logic [3:0]  id;
        logic [2:0]  de;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axis_fifo_if #(.DATA_WIDTH(32), .USER_WIDTH(2), .ID_WIDTH(4), .DEST_WIDTH(3)) s0 ();
    axis_fifo_if #(.DATA_WIDTH(32), .USER_WIDTH(2), .ID_WIDTH(4), .DEST_WIDTH(3)) m0 ();
    axis_fifo_if #(.DATA_WIDTH(32), .USER_WIDTH(2), .ID_WIDTH(4), .DEST_WIDTH(3)) s1 ();
    axis_fifo_if #(.DATA_WIDTH(32), .USER_WIDTH(2), .ID_WIDTH(4), .DEST_WIDTH(3)) m1 ();

    logic [4:0] occ0, occ1;
    logic       ov0, fd0, ov1, fd1;

    axis_fifo #(.DATA_WIDTH(32), .USER_WIDTH(2), .ID_WIDTH(4), .DEST_WIDTH(3),
                .DEPTH(16), .FRAME_FIFO(0), .DROP_OVERSIZE(0)) dut0 (
        .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0),
        .occupancy(occ0), .overflow(ov0), .frame_dropped(fd0));

    axis_fifo #(.DATA_WIDTH(32), .USER_WIDTH(2), .ID_WIDTH(4), .DEST_WIDTH(3),
                .DEPTH(16), .FRAME_FIFO(1), .DROP_OVERSIZE(1)) dut1 (
        .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1),
        .occupancy(occ1), .overflow(ov1), .frame_dropped(fd1));

    int    tests = 0;
    int    fails = 0;
    beat_t q0[$];
    beat_t q1[$];
    int    hs0_cyc = 0;
    bit    meas_en = 1'b0;
    int    out0_n = 0, out0_first = 0, out0_last = 0, max_occ0 = 0;
    int    ov0_cnt = 0, fd0_cnt = 0, ov1_cnt = 0, fd1_cnt = 0;
    bit    prev_stall0 = 1'b0;
    beat_t prev_b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t got0();
        return '{d: m0.tdata, k: m0.tkeep, l: m0.tlast, u: m0.tuser, id: m0.tid, de: m0.tdest};
    endfunction

    function automatic beat_t got1();
        return '{d: m1.tdata, k: m1.tkeep, l: m1.tlast, u: m1.tuser, id: m1.tid, de: m1.tdest};
    endfunction

    function automatic beat_t mk(input int i, input bit last);
        beat_t b;
        b.d  = 32'(i);
        b.k  = 4'(i);
        b.l  = last;
        b.u  = 2'(i);
        b.id = 4'(i >> 2);
        b.de = 3'(i >> 3);
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.d  = $urandom;
        b.k  = 4'($urandom);
        b.l  = ($urandom_range(0, 3) == 0);
        b.u  = 2'($urandom);
        b.id = 4'($urandom);
        b.de = 3'($urandom);
        return b;
    endfunction

    task automatic send0(input beat_t b, input bit rnd);
        int n;
        n = 0;
        s0.tdata = b.d; s0.tkeep = b.k; s0.tlast = b.l;
        s0.tuser = b.u; s0.tid = b.id; s0.tdest = b.de;
        s0.tvalid = 1'b1;
        @(negedge clk);
        while (!s0.tready && n < 100) begin
            @(posedge clk); #1;
            if (rnd) m0.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("wait_s0_ready", 64'(n < 100), 64'(1));
        if (s0.tready) begin
            q0.push_back(b);
            hs0_cyc = cyc;
        end
        @(posedge clk); #1;
        s0.tvalid = 1'b0;
        if (rnd) m0.tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send1(input beat_t b, input bit keep);
        int n;
        n = 0;
        s1.tdata = b.d; s1.tkeep = b.k; s1.tlast = b.l;
        s1.tuser = b.u; s1.tid = b.id; s1.tdest = b.de;
        s1.tvalid = 1'b1;
        @(negedge clk);
        while (!s1.tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_s1_ready", 64'(n < 100), 64'(1));
        if (s1.tready && keep) q1.push_back(b);
        @(posedge clk); #1;
        s1.tvalid = 1'b0;
    endtask

    task automatic drain0(input bit rnd);
        int n;
        n = 0;
        while (q0.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            if (rnd) m0.tready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("drain0_empty", 64'(q0.size()), 64'(0));
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while (q1.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain1_empty", 64'(q1.size()), 64'(0));
    endtask

    // Output monitors: a transfer seen at a falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall0 = 1'b0;
        end else begin
            if (prev_stall0) chk("hold0", 64'({m0.tvalid, got0()}), 64'({1'b1, prev_b0}));
            if (m0.tvalid && m0.tready) begin
                chk("q0_nonempty", 64'(q0.size() != 0), 64'(1));
                if (q0.size() != 0) chk("beat0", 64'(got0()), 64'(q0.pop_front()));
            end
            prev_stall0 = m0.tvalid && !m0.tready;
            prev_b0     = got0();
        end
        if (!meas_en) begin
            out0_n   = 0;
            max_occ0 = 0;
        end else begin
            if (int'(occ0) > max_occ0) max_occ0 = int'(occ0);
            if (m0.tvalid && m0.tready) begin
                if (out0_n == 0) out0_first = cyc;
                out0_last = cyc;
                out0_n++;
            end
        end
        if (ov0) ov0_cnt++;
        if (fd0) fd0_cnt++;
    end

    always @(negedge clk) begin
        if (rst && m1.tvalid && m1.tready) begin
            chk("q1_nonempty", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) chk("beat1", 64'(got1()), 64'(q1.pop_front()));
        end
        if (ov1) ov1_cnt++;
        if (fd1) fd1_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_in, fd_s, ov_s;
        s0.tvalid = 1'b0; s1.tvalid = 1'b0;
        s0.tdata = '0; s0.tkeep = '0; s0.tlast = 1'b0; s0.tuser = '0; s0.tid = '0; s0.tdest = '0;
        s1.tdata = '0; s1.tkeep = '0; s1.tlast = 1'b0; s1.tuser = '0; s1.tid = '0; s1.tdest = '0;
        m0.tready = 1'b0; m1.tready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tready0", 64'(s0.tready), 64'(0));
        chk("rst_tready1", 64'(s1.tready), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid0", 64'(m0.tvalid), 64'(0));
        chk("rst_occ0", 64'(occ0), 64'(0));
        chk("rst_ovf0", 64'(ov0), 64'(0));
        chk("rst_tvalid1", 64'(m1.tvalid), 64'(0));
        chk("rst_occ1", 64'(occ1), 64'(0));
        chk("rst_fdrop1", 64'(fd1), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_tready0", 64'(s0.tready), 64'(1));
        chk("post_rst_tready1", 64'(s1.tready), 64'(1));
        @(posedge clk); #1;

        // Fill to DEPTH with the consumer stalled, then drain in order
        for (int i = 0; i < 16; i++) send0(mk(i, i == 15), 1'b0);
        @(negedge clk);
        chk("fill_occ", 64'(occ0), 64'(16));
        chk("fill_tready", 64'(s0.tready), 64'(0));
        chk("fill_tvalid", 64'(m0.tvalid), 64'(1));
        @(posedge clk); #1;
        m0.tready = 1'b1;
        drain0(1'b0);
        @(negedge clk);
        chk("drained_occ", 64'(occ0), 64'(0));
        chk("drained_tready", 64'(s0.tready), 64'(1));
        @(posedge clk); #1;

        // Streaming: one beat per cycle, two-edge latency, occupancy at most 2
        meas_en  = 1'b1;
        first_in = 0;
        for (int i = 0; i < 100; i++) begin
            send0(mk(100 + i, (i % 10) == 9), 1'b0);
            if (i == 0) first_in = hs0_cyc;
        end
        chk("stream_in_rate", 64'(hs0_cyc - first_in), 64'(99));
        drain0(1'b0);
        chk("stream_count", 64'(out0_n), 64'(100));
        chk("stream_latency", 64'(out0_first - first_in), 64'(2));
        chk("stream_out_rate", 64'(out0_last - out0_first), 64'(99));
        chk("stream_max_occ", 64'(max_occ0 <= 2), 64'(1));
        meas_en = 1'b0;

        // Random valid/ready with random sideband
        for (int i = 0; i < 10000; i++) begin
            send0(rand_beat(), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                m0.tready = 1'($urandom_range(0, 1));
            end
        end
        drain0(1'b1);
        m0.tready = 1'b1;
        chk("no_overflow0", 64'(ov0_cnt), 64'(0));
        chk("no_fdrop0", 64'(fd0_cnt), 64'(0));

        // Store-and-forward: nothing leaves until tlast is written
        m1.tready = 1'b1;
        for (int i = 0; i < 4; i++) send1(mk(200 + i, 1'b0), 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_tvalid1", 64'(m1.tvalid), 64'(0));
        end
        @(posedge clk); #1;
        send1(mk(204, 1'b1), 1'b1);
        @(negedge clk);
        chk("commit_lat_a", 64'(m1.tvalid), 64'(0));
        @(negedge clk);
        chk("commit_lat_b", 64'(m1.tvalid), 64'(1));
        drain1();

        // Frame of exactly DEPTH beats is kept
        fd_s = fd1_cnt;
        for (int i = 0; i < 16; i++) send1(mk(300 + i, i == 15), 1'b1);
        drain1();
        @(negedge clk);
        chk("depth_frame_kept", 64'(fd1_cnt - fd_s), 64'(0));
        @(posedge clk); #1;

        // 20-beat frame dropped whole, following 3-beat frame delivered
        fd_s = fd1_cnt;
        ov_s = ov1_cnt;
        for (int i = 0; i < 20; i++) send1(mk(400 + i, i == 19), 1'b0);
        @(negedge clk);
        chk("drop_occ", 64'(occ1), 64'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send1(mk(500 + i, i == 2), 1'b1);
        drain1();
        @(negedge clk);
        chk("drop_fdrop_pulses", 64'(fd1_cnt - fd_s), 64'(1));
        chk("drop_overflow_beats", 64'(ov1_cnt - ov_s), 64'(4));
        @(posedge clk); #1;

        // Reset mid-frame with 7 stored beats
        for (int i = 0; i < 7; i++) send1(mk(600 + i, 1'b0), 1'b1);
        @(negedge clk);
        chk("pre_rst_occ1", 64'(occ1), 64'(7));
        chk("pre_rst_tvalid1", 64'(m1.tvalid), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tready1", 64'(s1.tready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        q1.delete();
        @(negedge clk);
        chk("after_rst_occ1", 64'(occ1), 64'(0));
        chk("after_rst_tvalid1", 64'(m1.tvalid), 64'(0));
        chk("after_rst_occ0", 64'(occ0), 64'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send1(mk(700 + i, i == 2), 1'b1);
        drain1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
